// File: rtl/color_grid_pkg.sv
// Shared types and constants for the color grid write path.
// Color bits are {B,G,R}; fill states drive the sweep FSM.
package color_grid_pkg;

  localparam int COLOR_W       = 3;
  localparam int R_BIT         = 0;
  localparam int G_BIT         = 1;
  localparam int B_BIT         = 2;
  localparam int GRID_BITS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_e;

  function automatic logic [COLOR_W-1:0] cell_color(
    input logic [COLOR_W-1:0] c,
    input logic               inv
  );
    return inv ? ~c : c;
  endfunction

endpackage

// File: rtl/color_grid_write_arbiter_if.sv
// Grid write port bundle: one strobe plus row, column and color.
// master drives the port, slave is the grid storage side.
interface color_grid_write_arbiter_if
  import color_grid_pkg::*;
#(
  parameter int GRID_BITS = GRID_BITS_DEF
) ();

  logic                 WR_EN;
  logic [GRID_BITS-1:0] WR_ROW;
  logic [GRID_BITS-1:0] WR_COL;
  logic [COLOR_W-1:0]   WR_DATA;

  modport master (
    output WR_EN,
    output WR_ROW,
    output WR_COL,
    output WR_DATA
  );

  modport slave (
    input WR_EN,
    input WR_ROW,
    input WR_COL,
    input WR_DATA
  );

endinterface

// File: rtl/key_edge_sync.sv
// Pushbutton synchronizer with history flop; pulses on a falling edge.
// Flops reset to 1 (button released). No debouncing is done here.
module key_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      hist <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_n};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign fall = hist & ~sync[SYNC_STAGES-1];

endmodule

// File: rtl/color_grid_write_arbiter.sv
// Grid write arbiter: manual button writes beat the 64-cell fill sweep.
// Define CHECKER_FILL_EN for a checkerboard fill (~color on odd parity).
module color_grid_write_arbiter
  import color_grid_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GRID_BITS   = GRID_BITS_DEF
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic                 KEY_WR_N,
  input  logic [GRID_BITS-1:0] MAN_ROW,
  input  logic [GRID_BITS-1:0] MAN_COL,
  input  logic [COLOR_W-1:0]   MAN_COLOR,
  input  logic                 FILL_START,
  input  logic [COLOR_W-1:0]   FILL_COLOR,
  color_grid_write_arbiter_if.master wr,
  output logic                 FILL_BUSY,
  output logic                 FILL_DONE
);

  localparam int CNT_W = 2 * GRID_BITS;

  fill_state_e          state;
  fill_state_e          state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [COLOR_W-1:0]   fcolor;
  logic                 man_req;
  logic                 fill_wr;
  logic                 start_ok;
  logic                 inv;
  logic [GRID_BITS-1:0] frow;
  logic [GRID_BITS-1:0] fcol;
  logic [COLOR_W-1:0]   fdata;

  key_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_key (
    .clk  (CLOCK_50),
    .rst_n(RESET_N),
    .key_n(KEY_WR_N),
    .fall (man_req)
  );

  assign frow     = cnt[CNT_W-1:GRID_BITS];
  assign fcol     = cnt[GRID_BITS-1:0];
  assign start_ok = (state == IDLE) && FILL_START;

`ifdef CHECKER_FILL_EN
  assign inv = frow[0] ^ fcol[0];
`else
  assign inv = 1'b0;
`endif

  assign fdata = cell_color(fcolor, inv);

  always_comb begin
    state_nx = state;
    fill_wr  = 1'b0;
    unique case (state)
      IDLE: if (FILL_START) state_nx = FILL;
      FILL: begin
        fill_wr = ~man_req;
        if (fill_wr && (&cnt)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      cnt    <= '0;
      fcolor <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        fcolor <= FILL_COLOR;
        cnt    <= '0;
      end else if (fill_wr) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Address/data hold their last value whenever no write issues.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      wr.WR_EN   <= 1'b0;
      wr.WR_ROW  <= '0;
      wr.WR_COL  <= '0;
      wr.WR_DATA <= '0;
      FILL_BUSY  <= 1'b0;
      FILL_DONE  <= 1'b0;
    end else begin
      wr.WR_EN  <= man_req | fill_wr;
      FILL_BUSY <= (state == FILL);
      FILL_DONE <= (state == DONE);
      unique case (1'b1)
        man_req: begin
          wr.WR_ROW  <= MAN_ROW;
          wr.WR_COL  <= MAN_COL;
          wr.WR_DATA <= MAN_COLOR;
        end
        fill_wr: begin
          wr.WR_ROW  <= frow;
          wr.WR_COL  <= fcol;
          wr.WR_DATA <= fdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_color_grid_write_arbiter.sv
// Directed bench for color_grid_write_arbiter.
// Writes are logged on the falling edge; checks use immediate asserts.
module tb_color_grid_write_arbiter;

  typedef struct {
    int r;
    int c;
    int d;
    int cyc;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       fstart = 1'b0;
  logic [2:0] mrow = '0;
  logic [2:0] mcol = '0;
  logic [2:0] mcolor = '0;
  logic [2:0] fcolor = '0;
  logic       busy;
  logic       done;

  int  cyc = 0;
  int  nbusy = 0;
  int  ndone = 0;
  int  done_cyc = -1;
  int  ncmp = 0;
  int  nerr = 0;
  int  s;
  int  bad;
  wr_t wq[$];

  color_grid_write_arbiter_if #(.GRID_BITS(3)) wr ();

  color_grid_write_arbiter #(
    .SYNC_STAGES(2),
    .GRID_BITS  (3)
  ) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .KEY_WR_N  (key_n),
    .MAN_ROW   (mrow),
    .MAN_COL   (mcol),
    .MAN_COLOR (mcolor),
    .FILL_START(fstart),
    .FILL_COLOR(fcolor),
    .wr        (wr.master),
    .FILL_BUSY (busy),
    .FILL_DONE (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    wr_t e;
    if (wr.WR_EN === 1'b1) begin
      e.r   = int'(wr.WR_ROW);
      e.c   = int'(wr.WR_COL);
      e.d   = int'(wr.WR_DATA);
      e.cyc = cyc;
      wq.push_back(e);
    end
    if (busy === 1'b1) nbusy++;
    if (done === 1'b1) begin
      ndone++;
      done_cyc = cyc;
    end
  end

  function automatic int fexp(input int col, input int r, input int k);
`ifdef CHECKER_FILL_EN
    return ((r ^ k) & 1) ? (~col & 7) : col;
`else
    return col;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int outs();
    return int'({wr.WR_EN, wr.WR_ROW, wr.WR_COL, wr.WR_DATA, busy, done});
  endfunction

  initial begin
    // reset held with the key toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      key_n = ~key_n;
      chk("rst_outs", outs(), 0);
    end
    key_n = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(10);
    chk("idle_no_wr", wq.size(), 0);

    // manual write, key held low 20 cycles
    mrow = 3'd5; mcol = 3'd2; mcolor = 3'b101;
    step(1);
    key_n = 1'b0;
    s = cyc;
    step(20);
    key_n = 1'b1;
    step(6);
    chk("man_count", wq.size(), 1);
    if (wq.size() >= 1) begin
      chk("man_row", wq[0].r, 5);
      chk("man_col", wq[0].c, 2);
      chk("man_data", wq[0].d, 5);
      chk("man_lat", wq[0].cyc, s + 3);
    end

    // uniform fill
    wq.delete(); nbusy = 0; ndone = 0;
`ifdef CHECKER_FILL_EN
    fcolor = 3'b001;
`else
    fcolor = 3'b010;
`endif
    fstart = 1'b1;
    s = cyc;
    step(1);
    fstart = 1'b0;
    step(75);
    chk("fill_busy", nbusy, 64);
    chk("fill_done", ndone, 1);
    chk("fill_count", wq.size(), 64);
    chk("fill_done_cyc", done_cyc, s + 66);
    chk("fill_idle", int'(busy), 0);
    bad = 0;
    for (int i = 0; i < 64 && i < wq.size(); i++) begin
      if (wq[i].r != i / 8 || wq[i].c != i % 8) bad++;
      if (wq[i].d != fexp(int'(fcolor), i / 8, i % 8)) bad++;
      if (wq[i].cyc != s + 2 + i) bad++;
    end
    chk("fill_order", bad, 0);
    if (wq.size() >= 10) begin
`ifdef CHECKER_FILL_EN
      chk("chk_00", wq[0].d, 1);
      chk("chk_01", wq[1].d, 6);
      chk("chk_11", wq[9].d, 1);
`else
      chk("uni_00", wq[0].d, 2);
      chk("uni_01", wq[1].d, 2);
      chk("uni_11", wq[9].d, 2);
`endif
    end

    // preemption at fill cycle 10, ignored restart at cycle 30
    wq.delete(); nbusy = 0; ndone = 0;
    mrow = 3'd6; mcol = 3'd6; mcolor = 3'b111;
    fcolor = 3'b011;
    fstart = 1'b1;
    s = cyc;
    step(1);
    fstart = 1'b0;
    step(8);
    key_n = 1'b0;
    step(21);
    fcolor = 3'b100;
    fstart = 1'b1;
    step(1);
    fstart = 1'b0;
    key_n = 1'b1;
    step(60);
    chk("pre_count", wq.size(), 65);
    chk("pre_busy", nbusy, 65);
    chk("pre_done", ndone, 1);
    if (wq.size() >= 12) begin
      chk("pre_man_rc", wq[10].r * 8 + wq[10].c, 54);
      chk("pre_man_d", wq[10].d, 7);
      chk("pre_man_cyc", wq[10].cyc, s + 12);
      chk("pre_retry_rc", wq[11].r * 8 + wq[11].c, 10);
      chk("pre_retry_d", wq[11].d, fexp(3, 1, 2));
      chk("pre_retry_cyc", wq[11].cyc, s + 13);
    end
    bad = 0;
    for (int i = 0; i < 65 && i < wq.size(); i++) begin
      int k;
      k = (i < 10) ? i : i - 1;
      if (wq[i].cyc != s + 2 + i) bad++;
      if (i != 10) begin
        if (wq[i].r != k / 8 || wq[i].c != k % 8) bad++;
        if (wq[i].d != fexp(3, k / 8, k % 8)) bad++;
      end
    end
    chk("pre_order", bad, 0);

    // reset in the middle of a fill
    wq.delete();
    fcolor = 3'b010;
    fstart = 1'b1;
    s = cyc;
    step(1);
    fstart = 1'b0;
    step(21);
    #1 rst_n = 1'b0;
    #1 chk("midrst_outs", outs(), 0);
    chk("midrst_count", wq.size(), 21);
    if (wq.size() >= 1)
      chk("midrst_last", wq[wq.size()-1].r * 8 + wq[wq.size()-1].c, 20);
    step(3);
    rst_n = 1'b1;
    step(5);
    chk("midrst_nowr", wq.size(), 21);
    chk("midrst_idle", int'(busy), 0);
    wq.delete();
    fstart = 1'b1;
    s = cyc;
    step(1);
    fstart = 1'b0;
    step(3);
    chk("restart_any", int'(wq.size() > 0), 1);
    if (wq.size() >= 1) begin
      chk("restart_rc", wq[0].r * 8 + wq[0].c, 0);
      chk("restart_cyc", wq[0].cyc, s + 2);
    end
    step(70);
    chk("restart_count", wq.size(), 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
